hazard_unit_param: RTL

- Parametrised successor to the fixed five-stage hazard control logic, for an N-stage in-order MIPS pipeline.
- Resolves per-stage stall and flush requests into per-pipeline-register stall/flush controls, with downstream-to-upstream stall propagation.
- Arbitrates PC redirects from any stage, with oldest-stage priority. A redirect that cannot apply is held in a pending register, and a configurable number of front-end bubbles follows each applied redirect.
- Keeps saturating per-stage stall statistics and a last-stage deadlock watchdog.

---
 rtl/hazard_unit_param.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/hazard_unit_param.sv
// Hazard control for an N-stage in-order pipeline: stall/flush
// resolution, oldest-first PC redirect arbitration, stall stats, watchdog.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall_req         per-stage stall request
//   flush_req         per-stage flush request
//   redir_valid       per-stage redirect pulse
//   redir_target      per-stage redirect target, ADDR_W bits each
//   stall_o           hold pipeline register i
//   flush_o           clear valid of pipeline register i
//   load_pc_we        PC overwrite strobe
//   load_pc_new       new PC value
//   redir_pending     a blocked redirect is waiting
//   stat_sel          stage index for stat_cnt
//   stat_clr          clear all stall counters
//   stat_cnt          stall cycle count of the selected stage
//   wdog_trip         sticky last-stage deadlock flag
module hazard_unit_param #(
  parameter int NUM_STAGES    = 5,
  parameter int ADDR_W        = 32,
  parameter int EXTRA_BUBBLES = 0,
  parameter int CNT_W         = 16,
  parameter int WDOG_LIMIT    = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_STAGES-1:0]        stall_req,
  input  logic [NUM_STAGES-1:0]        flush_req,
  input  logic [NUM_STAGES-1:0]        redir_valid,
  input  logic [NUM_STAGES*ADDR_W-1:0] redir_target,
  output logic [NUM_STAGES-1:0]        stall_o,
  output logic [NUM_STAGES-1:0]        flush_o,
  output logic                         load_pc_we,
  output logic [ADDR_W-1:0]            load_pc_new,
  output logic                         redir_pending,
  input  logic [2:0]                   stat_sel,
  input  logic                         stat_clr,
  output logic [CNT_W-1:0]             stat_cnt,
  output logic                         wdog_trip
);

  localparam int IW = $clog2(NUM_STAGES);
  localparam int WW = $clog2(WDOG_LIMIT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_BUBB = 2'd2;

  localparam logic [2:0] BUB_INIT =
    (EXTRA_BUBBLES > 0) ? 3'(EXTRA_BUBBLES - 1) : 3'd0;
  localparam logic [WW-1:0] WD_MAX = WW'(WDOG_LIMIT);
  localparam logic [WW-1:0] WD_PRE = WW'(WDOG_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     pidx_q, pidx_d;
  logic [ADDR_W-1:0] ptgt_q, ptgt_d;
  logic [2:0]        bub_q, bub_d;
  logic [CNT_W-1:0]  cnt_q [NUM_STAGES];
  logic [CNT_W-1:0]  cnt_d [NUM_STAGES];
  logic [WW-1:0]     run_q, run_d;
  logic              trip_q, trip_d;

  logic [NUM_STAGES-1:0] base;
  logic [NUM_STAGES-1:0] busy_above;
  logic                  cand_v;
  logic [IW-1:0]         cand_idx;
  logic [ADDR_W-1:0]     cand_tgt;
  logic                  pend_v;
  logic                  take_cand;
  logic                  win_v;
  logic [IW-1:0]         win_idx;
  logic [ADDR_W-1:0]     win_tgt;
  logic                  blk;
  logic                  apply;

  // A stalled stage also stalls every younger stage behind it.
  always_comb begin
    base = '0;
    base[NUM_STAGES-1] = stall_req[NUM_STAGES-1];
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      base[i] = stall_req[i] | base[i+1];
    end
  end

  // busy_above[j]: something older than stage j is stalled.
  assign busy_above = {1'b0, base[NUM_STAGES-1:1]};

  // Oldest (highest index) redirect wins.
  always_comb begin
    cand_v   = 1'b0;
    cand_idx = '0;
    cand_tgt = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      if (redir_valid[j]) begin
        cand_v   = 1'b1;
        cand_idx = IW'(j);
        cand_tgt = redir_target[j*ADDR_W +: ADDR_W];
      end
    end
  end

  assign pend_v    = (state_q == S_PEND);
  assign take_cand = cand_v & (~pend_v | (cand_idx >= pidx_q));
  assign win_v     = take_cand | pend_v;
  assign win_idx   = take_cand ? cand_idx : pidx_q;
  assign win_tgt   = take_cand ? cand_tgt : ptgt_q;
  assign blk       = busy_above[win_idx];
  assign apply     = win_v & ~blk;

  always_comb begin
    stall_o       = base;
    flush_o       = flush_req;
    load_pc_we    = 1'b0;
    load_pc_new   = win_tgt;
    redir_pending = win_v & blk;
    if (apply) begin
      load_pc_we = 1'b1;
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (IW'(i) < win_idx) begin
          flush_o[i] = 1'b1;
          stall_o[i] = 1'b0;
        end
      end
    end else begin
      if (win_v) begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (IW'(i) < win_idx) stall_o[i] = 1'b1;
        end
      end
      if (state_q == S_BUBB) flush_o[0] = 1'b1;
    end
    if (rst) begin
      stall_o       = '0;
      flush_o       = '1;
      load_pc_we    = 1'b0;
      redir_pending = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    pidx_d  = pidx_q;
    ptgt_d  = ptgt_q;
    bub_d   = bub_q;
    unique case (1'b1)
      apply: begin
        state_d = (EXTRA_BUBBLES > 0) ? S_BUBB : S_IDLE;
        bub_d   = BUB_INIT;
      end
      win_v & blk: begin
        state_d = S_PEND;
        pidx_d  = win_idx;
        ptgt_d  = win_tgt;
      end
      ~win_v & (state_q == S_BUBB): begin
        if (bub_q == 3'd0) state_d = S_IDLE;
        else               bub_d   = bub_q - 3'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr) begin
        cnt_d[i] = '0;
      end else if (stall_o[i] && cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stat_sel == 3'(i)) stat_cnt = cnt_q[i];
    end
  end

  // Run length of last-stage stall, saturating at the limit.
  always_comb begin
    run_d  = '0;
    trip_d = trip_q;
    if (stall_o[NUM_STAGES-1]) begin
      run_d = (run_q == WD_MAX) ? run_q : run_q + 1'b1;
      if (run_q >= WD_PRE) trip_d = 1'b1;
    end
  end

  assign wdog_trip = trip_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pidx_q  <= '0;
      ptgt_q  <= '0;
      bub_q   <= '0;
      run_q   <= '0;
      trip_q  <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pidx_q  <= pidx_d;
      ptgt_q  <= ptgt_d;
      bub_q   <= bub_d;
      run_q   <= run_d;
      trip_q  <= trip_d;
      for (int i = 0; i < NUM_STAGES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule
